// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multicycle controller: opcodes,
// operand-builder selects, mux selects, FSM states and trap causes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    IT_R = 4'd0, IT_I = 4'd1, IT_S = 4'd2, IT_B = 4'd3,
    IT_U = 4'd4, IT_J = 4'd5, IT_N = 4'd7
  } itype_e;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1} aluop_e;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_BRANCH = 2'd2} pcsel_e;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wbsel_e;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd7
  } state_e;

  typedef enum logic [1:0] {TC_NONE = 2'd0, TC_ILLEGAL = 2'd1, TC_TIMEOUT = 2'd2} cause_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: operand-builder select, ALU op and
// instruction class flags for the supported RV32I subset.
module instr_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  instr_type,
  output logic [1:0]  alu_op,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    instr_type = IT_N;
    alu_op     = ALU_ADD;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          instr_type = IT_R;
          alu_op     = funct7[5] ? ALU_SUB : ALU_ADD;
        end else illegal = 1'b1;
      end
      OPIMM: begin
        if (funct3 == 3'b000) instr_type = IT_I;
        else illegal = 1'b1;
      end
      LOAD: begin
        if (funct3 == 3'b010) begin
          instr_type = IT_I;
          is_load    = 1'b1;
        end else illegal = 1'b1;
      end
      STORE: begin
        if (funct3 == 3'b010) begin
          instr_type = IT_S;
          is_store   = 1'b1;
        end else illegal = 1'b1;
      end
      BRANCH: begin
        // funct3 000 = BEQ, 001 = BNE
        if (funct3[2:1] == 2'b00) begin
          instr_type = IT_B;
          alu_op     = ALU_SUB;
          is_branch  = 1'b1;
        end else illegal = 1'b1;
      end
      LUI:   instr_type = IT_U;
      AUIPC: instr_type = IT_J;
      JAL: begin
        instr_type = IT_J;
        is_jump    = 1'b1;
      end
      JALR: begin
        if (funct3 == 3'b000) begin
          instr_type = IT_I;
          is_jump    = 1'b1;
        end else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory ready handshake with stall watchdog, and trap on illegal/timeout.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [3:0]  instr_type,
  output logic [1:0]  alu_op,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_dbg
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         cause_q, cause_nxt;
  logic [3:0]         dec_type;
  logic [1:0]         dec_op;
  logic               is_load, is_store, is_branch, is_jump, illegal;
  logic               expired, taken;

  instr_decoder u_dec (
    .instr      (instr),
    .instr_type (dec_type),
    .alu_op     (dec_op),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .illegal    (illegal)
  );

  assign expired = (cnt == CNT_W'(TIMEOUT));
  assign taken   = instr[12] ? ~alu_zero : alu_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cnt     <= '0;
      cause_q <= TC_NONE;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (state == S_FETCH || state == S_MEM) cnt <= cnt + CNT_W'(1);
      if (state_nxt == S_TRAP && state != S_TRAP) cause_q <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = TC_NONE;
    instr_type   = IT_N;
    alu_op       = ALU_ADD;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (expired) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        instr_type = dec_type;
        alu_op     = dec_op;
        if (illegal) begin
          state_nxt = S_TRAP;
          cause_nxt = TC_ILLEGAL;
        end else state_nxt = S_EXEC;
      end
      S_EXEC: begin
        instr_type = dec_type;
        alu_op     = dec_op;
        if (is_branch) begin
          pc_we     = 1'b1;
          pc_sel    = taken ? PC_BRANCH : PC_PLUS4;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) state_nxt = S_MEM;
        else state_nxt = S_WB;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) begin
          mem_we = is_store;
          if (is_store) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else state_nxt = S_WB;
        end else begin
          // the store request is withdrawn in the cycle the watchdog fires
          mem_we = is_store & ~expired;
          if (expired) begin
            state_nxt = S_TRAP;
            cause_nxt = TC_TIMEOUT;
          end
        end
      end
      S_WB: begin
        instr_type = dec_type;
        alu_op     = dec_op;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        if (is_jump) begin
          wb_sel = WB_PC4;
          pc_sel = PC_ALU;
        end else if (is_load) wb_sel = WB_MEM;
        state_nxt = S_FETCH;
      end
      S_TRAP: ;
      default: state_nxt = S_FETCH;
    endcase
    // an instruction interrupted by reset must not commit anything
    if (rst) begin
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;
  assign state_dbg  = state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle control FSM for the RV32I-subset core (ADD, SUB, ADDI, LW, SW, BEQ, BNE, LUI, AUIPC, JAL, JALR).
- Sequences fetch/decode/execute/memory/writeback.
- Drives the operand builder's instr_type select, the ALU op and the PC/register-file/memory enables.
- Handles the instruction/data memory ready handshake, with a stall watchdog.
- Sits between the instruction register and the datapath mux/enable controls.

Parameters:
- TIMEOUT, 255, maximum cycles waiting on mem_ready before trapping (1..65535).
- CNT_W, 16, width of the stall counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- mem_ready  in  1  memory accepted/completed the current mem_req.
- alu_zero  in  1  ALU result == 0.
- instr_type  out  4  operand-builder select: R=0, I=1, S=2, B=3, U=4, J=5, N=7.
- alu_op  out  2  0=ADD, 1=SUB.
- ir_we  out  1  load instruction register from memory read data.
- pc_we  out  1  update PC.
- pc_sel  out  2  0=pc+4, 1=alu_result with bit0 cleared, 2=pc+imm (branch adder).
- rf_we  out  1  register-file write.
- wb_sel  out  2  0=alu_result, 1=mem_rdata, 2=pc+4.
- mem_req  out  1  memory access request.
- mem_we  out  1  store (qualified by mem_req).
- mem_addr_sel  out  1  0=pc, 1=alu_result.
- trap  out  1  core halted.
- trap_cause  out  2  0=none, 1=illegal instruction, 2=memory timeout.
- state_dbg  out  3  current state encoding.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. State, stall counter and trap_cause are registered. All other outputs are combinational from state and decoded instr.
- Reset (rst=1 at a clock edge):
  - State goes to FETCH, counter=0, trap_cause=0, trap=0.
  - No write enables fire in the reset cycle.
  - Reset mid-instruction aborts it with no PC, register-file or memory write.
- Outputs are 0 in any state unless listed below.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1: ir_we=1, next state DECODE. Otherwise stay and increment the counter.
- DECODE: one cycle, no enables. Operands settle.
  - Illegal opcode/funct → TRAP with cause 1.
  - Otherwise → EXEC.
- EXEC: instr_type and alu_op are valid.
  - R/ADDI/U: → WB.
  - LW/SW: → MEM.
  - BEQ/BNE: SUB. Branch taken when alu_zero==1 for BEQ, or alu_zero==0 for BNE. Taken: pc_we=1, pc_sel=2. Not taken: pc_we=1, pc_sel=0. Then → FETCH.
  - JAL/JALR: → WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW. Wait for mem_ready, counting stall cycles.
  - SW done: pc_we=1, pc_sel=0, → FETCH.
  - LW done: → WB.
- WB:
  - ALU instructions: rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
  - LW: wb_sel=1.
  - JAL/JALR: wb_sel=2, pc_we=1, pc_sel=1.
  - Then → FETCH.
- Decode map:
  - ADD/SUB → R. SUB when funct7[5]=1.
  - ADDI, LW, JALR → I.
  - SW → S.
  - BEQ/BNE → B.
  - LUI → U.
  - AUIPC and JAL → J (a=pc, b=imm).
  - alu_op=ADD except SUB and branches.
  - Outside DECODE/EXEC/WB, instr_type=N(7).
- Watchdog:
  - Counter clears on every state change.
  - If the counter reaches TIMEOUT while waiting in FETCH or MEM → TRAP with cause 2. No ir_we or write is issued that cycle.
  - A mem_ready arriving in the same cycle the counter equals TIMEOUT wins (completes normally).
- TRAP: trap=1, all enables 0, mem_req=0. Held until rst.
- Nominal latency with zero-wait memory:
  - ALU/U/JAL/JALR: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
- Exactly one pc_we pulse per retired instruction. At most one rf_we per instruction. Writes to x0 are ignored by the register file.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants: OP=0110011, OPIMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, LUI=0110111, AUIPC=0010111, JAL=1101111, JALR=1100111.
  - instr_type codes, alu_op, pc_sel, wb_sel, state and trap_cause encodings.
- One combinational sub-module, instr_decoder: instr → instr_type, alu_op, class flags (is_load, is_store, is_branch, is_jump, illegal).

Test Plan:
- ADD x3,x1,x2, mem_ready tied 1 → states 0,1,2,4,0. instr_type=0 in EXEC. rf_we and pc_we pulse once in cycle 4 with pc_sel=0.
- LW with mem_ready held low 3 cycles in MEM → MEM lasts 4 cycles. Then WB with wb_sel=1, rf_we=1. Total 8 cycles.
- BEQ with alu_zero=1 → pc_we=1, pc_sel=2 in EXEC, back to FETCH. Same with alu_zero=0 → pc_sel=0. BNE gives the inverse.
- JALR → EXEC instr_type=1. WB: wb_sel=2, pc_sel=1, rf_we=1, pc_we=1.
- mem_ready never asserted in FETCH, TIMEOUT=4 → TRAP after 4 stall cycles with trap_cause=2 and no ir_we. rst clears it to FETCH.
- Illegal opcode 0000000 → TRAP with cause 1 from DECODE. rst asserted during MEM of a SW → no mem_we next cycle, state FETCH.
